// File: rtl/operand_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_issue_stage
// Description : Selects and forwards ALU operands, detects load-use hazards
//               and holds one registered operand set behind a valid/ready pair.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_issue_stage #(
    parameter int XLEN    = 64,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic                   in_valid_in,
    output logic                   in_ready_out,
    input  logic [XLEN-1:0]        pc_in,
    input  logic [XLEN-1:0]        rs1_value_in,
    input  logic [XLEN-1:0]        rs2_value_in,
    input  logic [XLEN-1:0]        imm_value_in,
    input  logic [4:0]             rs1_idx_in,
    input  logic [4:0]             rs2_idx_in,
    input  logic [2:0]             alu_src_signal_in,
    input  logic [NUM_FWD-1:0]     fwd_valid_in,
    input  logic [NUM_FWD-1:0]     fwd_load_pending_in,
    input  logic [5*NUM_FWD-1:0]   fwd_rd_idx_in,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data_in,
    input  logic                   flush_in,
    output logic                   out_valid_out,
    input  logic                   out_ready_in,
    output logic [XLEN-1:0]        alu_value1_out,
    output logic [XLEN-1:0]        alu_value2_out,
    output logic [XLEN-1:0]        alu_value3_out,
    output logic                   stall_out,
    output logic [CNT_W-1:0]       stall_count_out
);

    localparam logic [2:0]       c_ALU_SRC_R1_R2    = 3'd0;
    localparam logic [2:0]       c_ALU_SRC_R1_IMM   = 3'd1;
    localparam logic [2:0]       c_ALU_SRC_PC_IMM   = 3'd2;
    localparam logic [2:0]       c_ALU_SRC_PC_FOUR  = 3'd3;
    localparam logic [2:0]       c_ALU_SRC_ZERO_IMM = 3'd4;
    localparam logic [CNT_W-1:0] c_CNT_MAX          = '1;

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [NUM_FWD-1:0] w_rs1_match;
    logic [NUM_FWD-1:0] w_rs2_match;
    logic               w_rs1_pend;
    logic               w_rs2_pend;
    logic [XLEN-1:0]    w_rs1_fwd;
    logic [XLEN-1:0]    w_rs2_fwd;
    logic               w_use_rs1_op1;
    logic               w_use_rs2_op2;
    logic [XLEN-1:0]    w_op1;
    logic [XLEN-1:0]    w_op2;
    logic               w_capture;

    logic [XLEN-1:0]    r_value1;
    logic [XLEN-1:0]    r_value2;
    logic [XLEN-1:0]    r_value3;
    logic [CNT_W-1:0]   r_stall_count;

    generate
        for (genvar k = 0; k < NUM_FWD; k++) begin : g_match
            assign w_rs1_match[k] = fwd_valid_in[k] && (rs1_idx_in != 5'd0)
                                    && (fwd_rd_idx_in[k*5 +: 5] == rs1_idx_in);
            assign w_rs2_match[k] = fwd_valid_in[k] && (rs2_idx_in != 5'd0)
                                    && (fwd_rd_idx_in[k*5 +: 5] == rs2_idx_in);
        end
    endgenerate

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        w_rs1_fwd  = rs1_value_in;
        w_rs2_fwd  = rs2_value_in;
        w_rs1_pend = 1'b0;
        w_rs2_pend = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (w_rs1_match[k]) begin
                w_rs1_fwd  = fwd_data_in[k*XLEN +: XLEN];
                w_rs1_pend = fwd_load_pending_in[k];
            end
            if (w_rs2_match[k]) begin
                w_rs2_fwd  = fwd_data_in[k*XLEN +: XLEN];
                w_rs2_pend = fwd_load_pending_in[k];
            end
        end
    end

    always_comb begin
        w_use_rs1_op1 = 1'b1;
        w_use_rs2_op2 = 1'b1;
        w_op1         = w_rs1_fwd;
        w_op2         = w_rs2_fwd;
        case (alu_src_signal_in)
            c_ALU_SRC_R1_IMM: begin
                w_use_rs2_op2 = 1'b0;
                w_op2         = imm_value_in;
            end
            c_ALU_SRC_PC_IMM: begin
                w_use_rs1_op1 = 1'b0;
                w_use_rs2_op2 = 1'b0;
                w_op1         = pc_in;
                w_op2         = imm_value_in;
            end
            c_ALU_SRC_PC_FOUR: begin
                w_use_rs1_op1 = 1'b0;
                w_use_rs2_op2 = 1'b0;
                w_op1         = pc_in;
                w_op2         = XLEN'(4);
            end
            c_ALU_SRC_ZERO_IMM: begin
                w_use_rs1_op1 = 1'b0;
                w_use_rs2_op2 = 1'b0;
                w_op1         = '0;
                w_op2         = imm_value_in;
            end
            c_ALU_SRC_R1_R2: begin
                w_use_rs1_op1 = 1'b1;
                w_use_rs2_op2 = 1'b1;
            end
            default: begin
                w_use_rs1_op1 = 1'b1;
                w_use_rs2_op2 = 1'b1;
            end
        endcase
    end

    // rs2 is always consumed as store data, so its hazard never depends on the select.
    assign stall_out     = in_valid_in && ((w_use_rs1_op1 && w_rs1_pend) || w_rs2_pend);
    assign out_valid_out = (r_state == S_FULL);
    assign in_ready_out  = !stall_out && (!out_valid_out || out_ready_in);
    assign w_capture     = in_valid_in && in_ready_out && !flush_in;

    always_comb begin
        w_state_next = r_state;
        if (flush_in) begin
            w_state_next = S_EMPTY;
        end else if (w_capture) begin
            w_state_next = S_FULL;
        end else if (out_valid_out && out_ready_in) begin
            w_state_next = S_EMPTY;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_value1 <= '0;
            r_value2 <= '0;
            r_value3 <= '0;
        end else if (w_capture) begin
            r_value1 <= w_op1;
            r_value2 <= w_op2;
            r_value3 <= w_rs2_fwd;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            r_stall_count <= '0;
        end else if (stall_out && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign alu_value1_out  = r_value1;
    assign alu_value2_out  = r_value2;
    assign alu_value3_out  = r_value3;
    assign stall_count_out = r_stall_count;

    // Usage flag for operand 2 documents intent; only operand 1 gates the hazard.
    logic w_unused_ok;
    assign w_unused_ok = w_use_rs2_op2;

endmodule
`default_nettype wire

// File: tb/tb_operand_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_issue_stage
// Description : Directed vector table plus stall/backpressure/flush/reset
//               sequences; a second instance with a 2-bit counter checks saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_issue_stage;

    localparam int         XLEN         = 64;
    localparam int         NF           = 2;
    localparam logic [2:0] SRC_R1_R2    = 3'd0;
    localparam logic [2:0] SRC_R1_IMM   = 3'd1;
    localparam logic [2:0] SRC_PC_IMM   = 3'd2;
    localparam logic [2:0] SRC_PC_FOUR  = 3'd3;
    localparam logic [2:0] SRC_ZERO_IMM = 3'd4;
    localparam int         NVEC         = 9;

    typedef struct {
        logic [2:0]       src;
        logic [63:0]      pc;
        logic [63:0]      rs1v;
        logic [63:0]      rs2v;
        logic [63:0]      imm;
        logic [4:0]       rs1i;
        logic [4:0]       rs2i;
        logic [1:0]       fv;
        logic [1:0]       fp;
        logic [9:0]       frd;
        logic [127:0]     fdata;
        logic [63:0]      e1;
        logic [63:0]      e2;
        logic [63:0]      e3;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready, s_in_ready;
    logic [XLEN-1:0]    pc, rs1v, rs2v, imm;
    logic [4:0]         rs1i, rs2i;
    logic [2:0]         src;
    logic [NF-1:0]      fv, fp;
    logic [5*NF-1:0]    frd;
    logic [XLEN*NF-1:0] fdata;
    logic               flush;
    logic               out_valid, s_out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    v1, v2, v3, s_v1, s_v2, s_v3;
    logic               stall, s_stall;
    logic [15:0]        cnt;
    logic [1:0]         s_cnt;

    int checks = 0;
    int errors = 0;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    operand_issue_stage #(.XLEN(XLEN), .NUM_FWD(NF), .CNT_W(16)) dut (
        .clk_in(clk), .reset_n_in(reset_n), .in_valid_in(in_valid), .in_ready_out(in_ready),
        .pc_in(pc), .rs1_value_in(rs1v), .rs2_value_in(rs2v), .imm_value_in(imm),
        .rs1_idx_in(rs1i), .rs2_idx_in(rs2i), .alu_src_signal_in(src),
        .fwd_valid_in(fv), .fwd_load_pending_in(fp), .fwd_rd_idx_in(frd), .fwd_data_in(fdata),
        .flush_in(flush), .out_valid_out(out_valid), .out_ready_in(out_ready),
        .alu_value1_out(v1), .alu_value2_out(v2), .alu_value3_out(v3),
        .stall_out(stall), .stall_count_out(cnt)
    );

    operand_issue_stage #(.XLEN(XLEN), .NUM_FWD(NF), .CNT_W(2)) dut_small (
        .clk_in(clk), .reset_n_in(reset_n), .in_valid_in(in_valid), .in_ready_out(s_in_ready),
        .pc_in(pc), .rs1_value_in(rs1v), .rs2_value_in(rs2v), .imm_value_in(imm),
        .rs1_idx_in(rs1i), .rs2_idx_in(rs2i), .alu_src_signal_in(src),
        .fwd_valid_in(fv), .fwd_load_pending_in(fp), .fwd_rd_idx_in(frd), .fwd_data_in(fdata),
        .flush_in(flush), .out_valid_out(s_out_valid), .out_ready_in(out_ready),
        .alu_value1_out(s_v1), .alu_value2_out(s_v2), .alu_value3_out(s_v3),
        .stall_out(s_stall), .stall_count_out(s_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        src   = v.src;
        pc    = v.pc;
        rs1v  = v.rs1v;
        rs2v  = v.rs2v;
        imm   = v.imm;
        rs1i  = v.rs1i;
        rs2i  = v.rs2i;
        fv    = v.fv;
        fp    = v.fp;
        frd   = v.frd;
        fdata = v.fdata;
    endtask

    initial begin
        //            src           pc        rs1v      rs2v      imm       rs1i  rs2i  fv     fp     frd {rd1,rd0}      fdata {d1,d0}              e1        e2        e3
        vecs[0] = '{SRC_R1_IMM,   64'h0,    64'h11,   64'h22,   64'h7,    5'd5, 5'd3, 2'b11, 2'b00, {5'd5, 5'd5},   {64'hBB, 64'hAA},          64'hAA,   64'h7,    64'h22};
        vecs[1] = '{SRC_R1_R2,    64'h0,    64'h31,   64'h12,   64'h0,    5'd1, 5'd0, 2'b01, 2'b00, {5'd9, 5'd0},   {64'h99, 64'hFF},          64'h31,   64'h12,   64'h12};
        vecs[2] = '{SRC_PC_FOUR,  64'h1000, 64'h99,   64'h3,    64'h0,    5'd2, 5'd7, 2'b11, 2'b01, {5'd7, 5'd2},   {64'h55, 64'h66},          64'h1000, 64'h4,    64'h55};
        vecs[3] = '{SRC_PC_IMM,   64'h2000, 64'h9,    64'h8,    64'h44,   5'd1, 5'd4, 2'b01, 2'b00, {5'd0, 5'd4},   {64'h0,  64'h77},          64'h2000, 64'h44,   64'h77};
        vecs[4] = '{SRC_ZERO_IMM, 64'h0,    64'h33,   64'h5,    64'hABC,  5'd3, 5'd6, 2'b01, 2'b00, {5'd0, 5'd3},   {64'h0,  64'hCC},          64'h0,    64'hABC,  64'h5};
        vecs[5] = '{SRC_R1_R2,    64'h0,    64'h13,   64'h16,   64'h0,    5'd3, 5'd6, 2'b11, 2'b00, {5'd3, 5'd6},   {64'hC1, 64'hD0},          64'hC1,   64'hD0,   64'hD0};
        vecs[6] = '{3'd7,         64'h0,    64'h123,  64'h456,  64'h9,    5'd1, 5'd2, 2'b00, 2'b00, {5'd2, 5'd1},   {64'hE2, 64'hE1},          64'h123,  64'h456,  64'h456};
        vecs[7] = '{SRC_R1_IMM,   64'h0,    64'h18,   64'hA0,   64'h10,   5'd8, 5'd10,2'b11, 2'b01, {5'd8, 5'd9},   {64'hE8, 64'hE9},          64'hE8,   64'h10,   64'hA0};
        vecs[8] = '{SRC_R1_R2,    64'h0,    64'h70,   64'h71,   64'h0,    5'd5, 5'd5, 2'b11, 2'b10, {5'd5, 5'd5},   {64'h2,  64'h1},           64'h1,    64'h1,    64'h1};

        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        apply(vecs[6]);
        tick();
        tick();
        chk("reset_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_value1", v1, 64'd0);
        chk("reset_value3", v3, 64'd0);
        chk("reset_count", {48'd0, cnt}, 64'd0);
        chk("reset_ready", {63'd0, in_ready}, 64'd1);

        reset_n = 1'b1;
        tick();
        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
            in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_stall", i), {63'd0, stall}, 64'd0);
            chk($sformatf("v%0d_ready", i), {63'd0, in_ready}, 64'd1);
            tick();
            chk($sformatf("v%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("v%0d_value1", i), v1, vecs[i].e1);
            chk($sformatf("v%0d_value2", i), v2, vecs[i].e2);
            chk($sformatf("v%0d_value3", i), v3, vecs[i].e3);
            chk($sformatf("v%0d_small_value1", i), s_v1, vecs[i].e1);
        end
        chk("count_before_stall", {48'd0, cnt}, 64'd0);

        // Load-use stall on rs1 for three cycles, then the data arrives.
        src = SRC_R1_R2; rs1i = 5'd5; rs1v = 64'h50; rs2i = 5'd0; rs2v = 64'h3;
        fv = 2'b01; fp = 2'b01; frd = {5'd0, 5'd5}; fdata = {64'h0, 64'h0};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall_c%0d", c), {63'd0, stall}, 64'd1);
            chk($sformatf("stall_ready_c%0d", c), {63'd0, in_ready}, 64'd0);
            tick();
        end
        chk("stall_count3", {48'd0, cnt}, 64'd3);
        chk("stall_small_count3", {62'd0, s_cnt}, 64'd3);
        chk("stall_drained", {63'd0, out_valid}, 64'd0);
        fp = 2'b00; fdata = {64'h0, 64'hAA};
        #1;
        chk("unstall", {63'd0, stall}, 64'd0);
        chk("unstall_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("stall_cap_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_cap_value1", v1, 64'hAA);
        chk("stall_cap_value2", v2, 64'h3);

        // Backpressure: held set stays stable, then back-to-back capture.
        out_ready = 1'b0;
        rs1i = 5'd1; rs1v = 64'h1111; rs2i = 5'd2; rs2v = 64'h2222; fv = 2'b00;
        #1;
        chk("bp_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk("bp_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_hold1", v1, 64'hAA);
        chk("bp_hold2", v2, 64'h3);
        tick();
        chk("bp_hold1b", v1, 64'hAA);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_value1", v1, 64'h1111);
        chk("b2b_value2", v2, 64'h2222);
        chk("b2b_value3", v3, 64'h2222);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // One more stall cycle: wide counter advances, narrow one saturates.
        in_valid = 1'b1; rs1i = 5'd5; fv = 2'b01; fp = 2'b01; frd = {5'd0, 5'd5};
        #1;
        chk("sat_stall", {63'd0, stall}, 64'd1);
        tick();
        chk("sat_count4", {48'd0, cnt}, 64'd4);
        chk("sat_small_count", {62'd0, s_cnt}, 64'd3);
        in_valid = 1'b0; fv = 2'b00; fp = 2'b00;

        // Flush in FULL with a capture attempt the same cycle.
        in_valid = 1'b1; rs1i = 5'd1; rs1v = 64'hF1;
        tick();
        chk("pre_flush_value1", v1, 64'hF1);
        rs1v = 64'hF2; flush = 1'b1;
        #1;
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_nocap", v1, 64'hF1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("post_flush_valid", {63'd0, out_valid}, 64'd0);

        // Reset in FULL with a capture attempt the same cycle.
        in_valid = 1'b1; rs1v = 64'hF3;
        tick();
        chk("pre_reset_value1", v1, 64'hF3);
        rs1v = 64'hF4; reset_n = 1'b0;
        #1;
        chk("reset_comb_ready", {63'd0, in_ready}, 64'd1);
        tick();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_value1", v1, 64'd0);
        chk("rst_value2", v2, 64'd0);
        chk("rst_value3", v3, 64'd0);
        chk("rst_count", {48'd0, cnt}, 64'd0);
        chk("rst_small_count", {62'd0, s_cnt}, 64'd0);
        chk("rst_small_valid", {63'd0, s_out_valid}, 64'd0);
        reset_n = 1'b1; in_valid = 1'b0;
        tick();
        chk("small_ready", {63'd0, s_in_ready}, 64'd1);
        chk("small_stall", {63'd0, s_stall}, 64'd0);
        chk("small_value2", s_v2, 64'd0);
        chk("small_value3", s_v3, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_issue_stage.md
OPERAND_ISSUE_STAGE -- requirements
Module: Operand_Issue_Stage

Interface
REQ-001 Parameter XLEN, default 64: operand/data width in bits.
REQ-002 Parameter NUM_FWD, default 2: number of forwarding sources; index 0 is the youngest (EX/MEM), higher indices are older.
REQ-003 Parameter CNT_W, default 16: stall counter width.
REQ-004 clk_in  input  1: single clock; all state updates on rising edge.
REQ-005 reset_n_in  input  1: reset, synchronous, active-low.
REQ-006 in_valid_in / in_ready_out  input/output  1/1: upstream operand handshake.
REQ-007 pc_in, rs1_value_in, rs2_value_in, imm_value_in  input  XLEN each: candidate operands.
REQ-008 rs1_idx_in, rs2_idx_in  input  5 each: source register indices.
REQ-009 alu_src_signal_in  input  3: operand-pair select, ALU_SRC_* encodings from Opcodes.vh.
REQ-010 fwd_valid_in, fwd_load_pending_in  input  NUM_FWD each: per-source valid and "data not yet available" flags.
REQ-011 fwd_rd_idx_in  input  5*NUM_FWD; fwd_data_in  input  XLEN*NUM_FWD: per-source destination index and result, source k in slice k.
REQ-012 flush_in  input  1: discard the held operand set.
REQ-013 out_valid_out / out_ready_in  output/input  1/1: downstream handshake.
REQ-014 alu_value1_out, alu_value2_out, alu_value3_out  output  XLEN each: registered ALU operands and store data.
REQ-015 stall_out  output  1: combinational load-use stall indication.
REQ-016 stall_count_out  output  CNT_W: saturating count of stall cycles.

Function
REQ-017 Base select: R1_R2 -> (rs1,rs2); R1_IMM -> (rs1,imm); PC_IMM -> (pc,imm); PC_FOUR -> (pc,4); ZERO_IMM -> (0,imm); any other code -> (rs1,rs2).
REQ-018 Operand-1 forwarding applies only when base operand 1 is rs1; operand-2 forwarding only when base operand 2 is rs2.
REQ-019 Operand 3 is always forwarded rs2 (store data), regardless of alu_src_signal_in.
REQ-020 Source k matches register r when fwd_valid_in[k]=1, fwd_rd_idx_in[k]==r and r!=0; register 0 never forwards, always reads as rs value input.
REQ-021 Multiple matches: lowest index (youngest) wins; no match -> register-file value.
REQ-022 Load-use: stall_out=1 when in_valid_in=1 and the winning match for any used register (rs1 if operand 1 uses it, rs2 always) has fwd_load_pending_in=1.
REQ-023 in_ready_out = !stall_out && (!out_valid_out || out_ready_in); combinational, no dependence on in_valid_in except via stall.
REQ-024 Capture: when in_valid_in && in_ready_out, operands latch and out_valid_out=1 next cycle; latency 1 cycle.
REQ-025 When out_valid_out && out_ready_in and no capture, out_valid_out=0 next cycle; simultaneous drain and capture keeps out_valid_out=1 with new data (full throughput).
REQ-026 While out_valid_out=1 and out_ready_in=0, output values SHALL hold stable.
REQ-027 flush_in=1: out_valid_out=0 next cycle, no capture that cycle, overriding REQ-024/025; in_ready_out unaffected.
REQ-028 stall_count_out increments by 1 each cycle stall_out=1, saturates at all-ones, never wraps.
REQ-029 State: EMPTY (out_valid_out=0) / FULL (out_valid_out=1); EMPTY->FULL on capture; FULL->EMPTY on drain without capture or flush; otherwise hold.

Reset
REQ-030 reset_n_in=0 at a clock edge: out_valid_out=0, alu_value1/2/3_out=0, stall_count_out=0, state EMPTY; takes priority over capture and flush.
REQ-031 Reset mid-transfer discards the held operand set; no partial update survives.
REQ-032 stall_out and in_ready_out are combinational and follow REQ-022/023 during reset.

Verification
REQ-033 R1_IMM, rs1_idx=5, fwd0 valid rd=5 data=0xAA, fwd1 valid rd=5 data=0xBB -> value1=0xAA, value2=imm, one cycle after capture.
REQ-034 R1_R2, rs2_idx=0, fwd0 valid rd=0 data=0xFF, rs2_value=0x12 -> value2=0x12, value3=0x12.
REQ-035 PC_FOUR, pc=0x1000, rs2_idx=7 matched by fwd1 data=0x55 -> value1=0x1000, value2=4, value3=0x55.
REQ-036 rs1 matched by fwd0 with load_pending=1 for 3 cycles -> stall_out=1, in_ready_out=0 for 3 cycles, stall_count_out=3, capture on 4th cycle.
REQ-037 out_ready_in=0 with FULL, new input valid -> in_ready_out=0, outputs stable; out_ready_in=1 -> back-to-back capture, out_valid_out stays 1.
REQ-038 flush_in and reset_n_in=0 asserted in FULL state -> out_valid_out=0 next cycle; reset additionally zeroes outputs and counter.
